// File: rtl/cpu_pkg.sv
// cpu_pkg: shared port width, monitor defaults and the queued entry layout.
package cpu_pkg;
  localparam int PORT_W = 8;
  localparam int TS_W = 16;
  localparam int MON_DEPTH = 8;
  typedef struct packed {
    logic [PORT_W-1:0] data;
    logic [TS_W-1:0]   ts;
  } entry_t;
  localparam int ENTRY_W = $bits(entry_t);
endpackage

// File: rtl/port_fifo.sv
// port_fifo: synchronous FIFO with flush, separate occupancy count and zeroed output when empty.
module port_fifo #(
  parameter int W = 24,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [W-1:0]               data_i,
  output logic                       valid_o,
  output logic [W-1:0]               data_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] count_q, count_d;
  logic do_push, do_pop;
  assign valid_o = count_q != '0;
  assign full_o = count_q == (AW+1)'(DEPTH);
  assign do_pop = pop_i & valid_o;
  // a full FIFO still accepts a push when the head leaves in the same cycle
  assign do_push = push_i & (~full_o | do_pop);
  assign data_o = valid_o ? mem_q[rd_q] : '0;
  assign count_o = count_q;
  always_comb begin
    wr_d = flush_i ? '0 : wr_q + AW'(do_push);
    rd_d = flush_i ? '0 : rd_q + AW'(do_pop);
    count_d = flush_i ? '0 : count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_q] <= data_i;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
      count_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      count_q <= count_d;
    end
  end
endmodule

// File: rtl/port_monitor.sv
// port_monitor: samples the CPU output port, queues each changed value with a timestamp.
module port_monitor
  import cpu_pkg::*;
#(
  parameter int DW = PORT_W,
  parameter int TSW = TS_W,
  parameter int DEPTH = MON_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en_i,
  input  logic                   clr_i,
  input  logic [DW-1:0]          port_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [DW-1:0]          out_data_o,
  output logic [TSW-1:0]         out_ts_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   overflow_o
);
  logic [DW-1:0] port_q, last_q, last_d;
  logic [TSW-1:0] ts_q, ts_d;
  logic ovf_q, ovf_d, chg, pop, full;
  assign chg = en_i & (port_q != last_q);
  assign pop = out_valid_o & out_ready_i;
  // clear wins: the pending change is not consumed, so it is captured right after
  always_comb begin
    last_d = (chg & ~clr_i) ? port_q : last_q;
    ts_d = clr_i ? '0 : ts_q + TSW'(1);
    ovf_d = clr_i ? 1'b0 : ovf_q | (chg & full & ~pop);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      port_q <= '0;
      last_q <= '0;
      ts_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      port_q <= port_i;
      last_q <= last_d;
      ts_q <= ts_d;
      ovf_q <= ovf_d;
    end
  end
  assign overflow_o = ovf_q;
  port_fifo #(.W(DW + TSW), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .flush_i(clr_i),
    .push_i(chg & ~clr_i),
    .pop_i(pop),
    .data_i({port_q, ts_q}),
    .valid_o(out_valid_o),
    .data_o({out_data_o, out_ts_o}),
    .count_o(count_o),
    .full_o(full)
  );
endmodule

// File: tb/tb_port_monitor.sv
// tb_port_monitor: directed vector table plus hand-written multi-cycle sequences.
module tb_port_monitor;
  logic clk = 1'b0, rst_n = 1'b1, en = 1'b1, clr = 1'b0, ready = 1'b0;
  logic [7:0] port = '0;
  logic valid, ovf;
  logic [7:0] data;
  logic [15:0] ts;
  logic [3:0] count;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  port_monitor dut (
    .clk(clk), .rst_n(rst_n), .en_i(en), .clr_i(clr), .port_i(port),
    .out_valid_o(valid), .out_ready_i(ready), .out_data_o(data),
    .out_ts_o(ts), .count_o(count), .overflow_o(ovf)
  );
  typedef struct {
    logic en, rdy;
    logic [7:0] port;
    logic v;
    logic [7:0] d;
    logic [15:0] ts;
    logic [3:0] cnt;
    logic ovf;
  } vec_t;
  vec_t vt[15];
  function automatic vec_t mk(logic e, logic r, logic [7:0] p, logic v, logic [7:0] d,
                              logic [15:0] t, logic [3:0] c, logic o);
    vec_t x;
    x.en = e; x.rdy = r; x.port = p; x.v = v; x.d = d; x.ts = t; x.cnt = c; x.ovf = o;
    return x;
  endfunction
  task automatic chk(string n, logic [63:0] a, logic [63:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    en = 1'b1; clr = 1'b0; port = '0; ready = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask
  initial begin
    // edge k after reset leaves ts=k; a value sampled at edge k is pushed at k+1 with ts=k
    vt[0]  = mk(1, 0, 8'h00, 0, 8'h00, 0, 0, 0);
    vt[1]  = mk(1, 0, 8'h5A, 0, 8'h00, 0, 0, 0);
    vt[2]  = mk(1, 0, 8'h5A, 1, 8'h5A, 2, 1, 0);
    vt[3]  = mk(1, 0, 8'h5A, 1, 8'h5A, 2, 1, 0);
    vt[4]  = mk(1, 0, 8'h5A, 1, 8'h5A, 2, 1, 0);
    vt[5]  = mk(1, 0, 8'h5A, 1, 8'h5A, 2, 1, 0);
    vt[6]  = mk(1, 1, 8'h5A, 0, 8'h00, 0, 0, 0);
    vt[7]  = mk(1, 1, 8'h5A, 0, 8'h00, 0, 0, 0);
    vt[8]  = mk(1, 0, 8'h01, 0, 8'h00, 0, 0, 0);
    vt[9]  = mk(1, 0, 8'h02, 1, 8'h01, 9, 1, 0);
    vt[10] = mk(1, 0, 8'h02, 1, 8'h01, 9, 2, 0);
    vt[11] = mk(1, 1, 8'h02, 1, 8'h02, 10, 1, 0);
    vt[12] = mk(0, 1, 8'h33, 0, 8'h00, 0, 0, 0);
    vt[13] = mk(0, 0, 8'h33, 0, 8'h00, 0, 0, 0);
    vt[14] = mk(1, 0, 8'h33, 1, 8'h33, 14, 1, 0);
    do_reset();
    chk("reset_state", {valid, data, ts, count, ovf}, 30'd0);
    for (int i = 0; i < 15; i++) begin
      en = vt[i].en; ready = vt[i].rdy; port = vt[i].port;
      step();
      chk($sformatf("vec%0d", i), {valid, data, ts, count, ovf},
          {vt[i].v, vt[i].d, vt[i].ts, vt[i].cnt, vt[i].ovf});
    end
    // async reset in the middle of a cycle with an entry queued
    #2 rst_n = 1'b0;
    #1 chk("async_reset", {valid, data, ts, count, ovf}, 30'd0);
    @(posedge clk);
    #1 rst_n = 1'b1; port = '0; en = 1'b1;
    repeat (3) step();
    chk("post_reset_idle", {valid, count}, 5'd0);
    // burst of 10 changes into 8 entries
    do_reset();
    for (int k = 1; k <= 10; k++) begin
      port = 8'(k);
      step();
    end
    step();
    chk("burst_count", count, 8);
    chk("burst_ovf", ovf, 1);
    ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      chk($sformatf("burst_head%0d", i), {valid, data, ts}, {1'b1, 8'(i), 16'(i)});
      step();
    end
    ready = 1'b0;
    chk("burst_drained", {valid, count, ovf}, {1'b0, 4'd0, 1'b1});
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("clr_ovf", ovf, 0);
    // push and pop together while full
    do_reset();
    for (int k = 1; k <= 8; k++) begin
      port = 8'(k);
      step();
    end
    step();
    chk("full_count", {count, ovf}, {4'd8, 1'b0});
    port = 8'd9;
    step();
    ready = 1'b1;
    step();
    ready = 1'b0;
    chk("full_pushpop", {count, ovf, data}, {4'd8, 1'b0, 8'd2});
    ready = 1'b1;
    for (int i = 2; i <= 9; i++) begin
      chk($sformatf("full_head%0d", i), {data, ts}, {8'(i), (i == 9) ? 16'd10 : 16'(i)});
      step();
    end
    ready = 1'b0;
    chk("full_drained", {valid, count, ovf}, 6'd0);
    // enable gating and clear
    do_reset();
    en = 1'b0; port = 8'h11;
    step(); step();
    port = 8'h22;
    step(); step();
    chk("en_off", {valid, count}, 5'd0);
    en = 1'b1;
    step();
    chk("reenable", {valid, data, ts}, {1'b1, 8'h22, 16'd4});
    port = 8'h23; step();
    port = 8'h24; step();
    step();
    chk("clr_pre", count, 3);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("clr_post", {valid, count, ovf}, 6'd0);
    port = 8'h25;
    step(); step();
    chk("ts_restart", {valid, data, ts}, {1'b1, 8'h25, 16'd1});
    // timestamp wrap
    do_reset();
    repeat (65534) step();
    port = 8'h77; step();
    port = 8'h78; step();
    step();
    chk("wrap_first", {count, data, ts}, {4'd2, 8'h77, 16'hFFFF});
    ready = 1'b1;
    step();
    ready = 1'b0;
    chk("wrap_second", {count, data, ts}, {4'd1, 8'h78, 16'h0000});
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
